dmem_lsu: RTL

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/dmem_lsu_if.sv | 37 +++
 rtl/dmem_lsu_load_extend.sv | 43 ++++
 rtl/dmem_lsu.sv | 131 +++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings and LSU state type, plus store-side
// lane helpers used by the data-memory load/store unit.
package riscv_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } lsu_state_t;

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3)
         SB:      be = 4'b0001 << off;
         SH:      be = off[1] ? 4'b1100 : 4'b0011;
         SW:      be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Narrow stores replicate their low byte/half so any selected lane sees it.
   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
      logic [31:0] d;
      case (f3)
         SB:      d = {4{w[7:0]}};
         SH:      d = {2{w[15:0]}};
         default: d = w;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-request / SRAM bundle for the load/store unit; the LSU takes the
// slave view, the environment (core + SRAM model) takes the master view.
interface dmem_lsu_if #(parameter int WORD_AW = 8);

   logic               req_valid;
   logic               req_we;
   logic [2:0]         funct3;
   logic [31:0]        addr;
   logic [31:0]        wdata;
   logic               stall;
   logic [31:0]        rdata;
   logic               rvalid;
   logic               fault;
   logic               mem_en;
   logic               mem_we;
   logic [3:0]         mem_be;
   logic [WORD_AW-1:0] mem_addr;
   logic [31:0]        mem_wdata;
   logic [31:0]        mem_rdata;
   logic [31:0]        load_cnt;
   logic [31:0]        store_cnt;

   modport slave (
      input  req_valid, req_we, funct3, addr, wdata, mem_rdata,
      output stall, rdata, rvalid, fault,
      output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      output load_cnt, store_cnt
   );

   modport master (
      output req_valid, req_we, funct3, addr, wdata, mem_rdata,
      input  stall, rdata, rvalid, fault,
      input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
      input  load_cnt, store_cnt
   );

endinterface

// File: rtl/dmem_lsu_load_extend.sv
// Combinational lane select and sign/zero extension of SRAM read data
// according to the latched load funct3 and byte offset.
module load_extend
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte and half-word lanes.
   always_comb begin
      case (offset)
         2'd0:    byte_s = raw[7:0];
         2'd1:    byte_s = raw[15:8];
         2'd2:    byte_s = raw[23:16];
         2'd3:    byte_s = raw[31:24];
         default: byte_s = 8'h00;
      endcase
      if (offset[1]) begin
         half_s = raw[31:16];
      end else begin
         half_s = raw[15:0];
      end
   end

   // Extend the selected lane to a full register value.
   always_comb begin
      case (funct3)
         LB:      data = {{24{byte_s[7]}}, byte_s};
         LBU:     data = {24'h000000, byte_s};
         LH:      data = {{16{half_s[15]}}, half_s};
         LHU:     data = {16'h0000, half_s};
         LW:      data = raw;
         default: data = 32'h00000000;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: stores complete in one cycle, loads take one
// stall cycle plus a read-wait cycle against a synchronous external SRAM.
module dmem_lsu
   import riscv_pkg::*;
#(
   parameter int WORD_AW = 8
)(
   input  logic       clk,
   input  logic       reset,
   dmem_lsu_if.slave  bus
);

   lsu_state_t  state_r, state_s;
   logic [2:0]  f3_r;
   logic [1:0]  off_r;
   logic [31:0] load_cnt_r, store_cnt_r;

   logic        f3_bad_s, misalign_s, range_bad_s, reject_s;
   logic        stall_s, rvalid_s, fault_s, en_s, we_s;
   logic        latch_s, ld_inc_s, st_inc_s;
   logic [3:0]  be_s;
   logic [31:0] rdata_s, ext_s;

   load_extend u_load_extend (
      .funct3 (f3_r),
      .offset (off_r),
      .raw    (bus.mem_rdata),
      .data   (ext_s)
   );

   // Request legality: funct3 vs. direction, alignment, address range.
   always_comb begin
      if (bus.req_we) begin
         case (bus.funct3)
            SB, SH, SW: f3_bad_s = 1'b0;
            default:    f3_bad_s = 1'b1;
         endcase
      end else begin
         case (bus.funct3)
            LB, LH, LW, LBU, LHU: f3_bad_s = 1'b0;
            default:              f3_bad_s = 1'b1;
         endcase
      end
      misalign_s  = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                    ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
      range_bad_s = |bus.addr[31:WORD_AW+2];
      reject_s    = f3_bad_s | misalign_s | range_bad_s;
   end

   // Next state and strobes; reset forces every strobe low.
   always_comb begin
      state_s  = state_r;
      stall_s  = 1'b0;
      rvalid_s = 1'b0;
      fault_s  = 1'b0;
      en_s     = 1'b0;
      we_s     = 1'b0;
      be_s     = 4'h0;
      rdata_s  = 32'h00000000;
      latch_s  = 1'b0;
      ld_inc_s = 1'b0;
      st_inc_s = 1'b0;
      if (!reset) begin
         state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (!bus.req_valid) begin
                  state_s = IDLE;
               end else if (reject_s) begin
                  fault_s = 1'b1;
               end else if (bus.req_we) begin
                  en_s     = 1'b1;
                  we_s     = 1'b1;
                  be_s     = store_be(bus.funct3, bus.addr[1:0]);
                  st_inc_s = 1'b1;
               end else begin
                  en_s    = 1'b1;
                  be_s    = 4'hF;
                  stall_s = 1'b1;
                  latch_s = 1'b1;
                  state_s = RD_WAIT;
               end
            end
            RD_WAIT: begin
               rvalid_s = 1'b1;
               rdata_s  = ext_s;
               ld_inc_s = 1'b1;
               state_s  = IDLE;
            end
            default: state_s = IDLE;
         endcase
      end
   end

   // State, latched load attributes and completion counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= IDLE;
         f3_r        <= 3'b000;
         off_r       <= 2'b00;
         load_cnt_r  <= 32'h00000000;
         store_cnt_r <= 32'h00000000;
      end else begin
         state_r <= state_s;
         if (latch_s) begin
            f3_r  <= bus.funct3;
            off_r <= bus.addr[1:0];
         end
         if (ld_inc_s) begin
            load_cnt_r <= load_cnt_r + 32'd1;
         end
         if (st_inc_s) begin
            store_cnt_r <= store_cnt_r + 32'd1;
         end
      end
   end

   assign bus.stall     = stall_s;
   assign bus.rvalid    = rvalid_s;
   assign bus.rdata     = rdata_s;
   assign bus.fault     = fault_s;
   assign bus.mem_en    = en_s;
   assign bus.mem_we    = we_s;
   assign bus.mem_be    = be_s;
   assign bus.mem_addr  = bus.addr[WORD_AW+1:2];
   assign bus.mem_wdata = store_data(bus.funct3, bus.wdata);
   assign bus.load_cnt  = load_cnt_r;
   assign bus.store_cnt = store_cnt_r;

endmodule
